fp_subtractor_seq: RTL and testbench

//  Multi-cycle IEEE-754 single-precision subtractor: out_data = in_data_A - in_data_B.

---
 rtl/fp_subtractor_seq.sv | 146 ++++++++++++++
 tb/tb_fp_subtractor_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (A - B) with start/done handshake.
// Truncating, denormals flushed to zero; exact zero results are returned as 32'h80000000.
module fp_subtractor_seq #(
  parameter int WIDTH = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:WIDTH-1] in_data_A,
  input  logic [0:WIDTH-1] in_data_B,
  output logic             busy,
  output logic [0:WIDTH-1] out_data,
  output logic             done,
  output logic             overflow,
  underflow
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_SUB, S_NORM, S_PACK, S_DONE} state_t;

  localparam logic signed [EXP_W+1:0] EXP_ONE = 1;
  localparam logic signed [EXP_W+1:0] EXP_MAX = 254;
  localparam logic [EXP_W-1:0]        SH_MAX  = EXP_W'(MAN_W + 1);
  localparam logic [4:0]              NORM_LAST = 5'(MAN_W);

  state_t                   st;
  logic [WIDTH-1:0]         a_reg, b_reg;
  logic [MAN_W:0]           ma, mb;
  logic                     sa, sb, sgn;
  logic [MAN_W+1:0]         m;
  logic signed [EXP_W+1:0]  exp_r;
  logic [4:0]               cnt;

  logic [EXP_W-1:0] ea, eb, diff, big_e;
  logic [MAN_W:0]   fa, fb, small_m, small_sh;
  logic             a_big;

  // Alignment: the smaller-exponent operand is shifted right in one step, shifted-out bits dropped.
  always_comb begin
    ea       = a_reg[WIDTH-2 -: EXP_W];
    eb       = b_reg[WIDTH-2 -: EXP_W];
    fa       = (ea == '0) ? '0 : {1'b1, a_reg[MAN_W-1:0]};
    fb       = (eb == '0) ? '0 : {1'b1, b_reg[MAN_W-1:0]};
    a_big    = (ea >= eb);
    diff     = a_big ? (ea - eb) : (eb - ea);
    big_e    = a_big ? ea : eb;
    small_m  = a_big ? fb : fa;
    small_sh = (diff > SH_MAX) ? '0 : (small_m >> diff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      ma        <= '0;
      mb        <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      sgn       <= 1'b0;
      m         <= '0;
      exp_r     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (start) begin
            a_reg <= in_data_A;
            b_reg <= {~in_data_B[0], in_data_B[1:WIDTH-1]};
            busy  <= 1'b1;
            st    <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          ma    <= a_big ? fa : small_sh;
          mb    <= a_big ? small_sh : fb;
          exp_r <= {2'b00, big_e};
          sa    <= a_reg[WIDTH-1];
          sb    <= b_reg[WIDTH-1];
          st    <= S_SUB;
        end
        S_SUB: begin
          if (sa == sb) begin
            m   <= {1'b0, ma} + {1'b0, mb};
            sgn <= sa;
          end else if (ma >= mb) begin
            m   <= {1'b0, ma - mb};
            sgn <= sa;
          end else begin
            m   <= {1'b0, mb - ma};
            sgn <= sb;
          end
          cnt <= '0;
          st  <= S_NORM;
        end
        S_NORM: begin
          if (m[MAN_W+1]) begin
            m     <= m >> 1;
            exp_r <= exp_r + EXP_ONE;
            st    <= S_PACK;
          end else if (m == '0 || m[MAN_W] || cnt == NORM_LAST) begin
            st <= S_PACK;
          end else begin
            m     <= m << 1;
            exp_r <= exp_r - EXP_ONE;
            cnt   <= cnt + 5'd1;
          end
        end
        S_PACK: begin
          if (m == '0) begin
            out_data  <= {1'b1, {(WIDTH-1){1'b0}}};
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end else if (exp_r > EXP_MAX) begin
            out_data  <= {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow  <= 1'b1;
            underflow <= 1'b0;
          end else if (exp_r < EXP_ONE) begin
            out_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b1;
          end else begin
            out_data  <= {sgn, exp_r[EXP_W-1:0], m[MAN_W-1:0]};
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end
          busy <= 1'b0;
          done <= 1'b1;
          st   <= S_DONE;
        end
        S_DONE: begin
          done <= 1'b0;
          st   <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Scoreboard bench for fp_subtractor_seq: expected results queued at start, compared on done.
module tb_fp_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [0:31] in_data_A = '0;
  logic [0:31] in_data_B = '0;
  logic [0:31] out_data;
  logic        busy, done, overflow, underflow;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [33:0] sb_q[$];
  string       tag_q[$];
  logic [33:0] exp_v;
  string       exp_tag;

  fp_subtractor_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data_A(in_data_A), .in_data_B(in_data_B),
    .busy(busy), .out_data(out_data), .done(done),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  // Scoreboard: every done pulse consumes the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        exp_v   = sb_q.pop_front();
        exp_tag = tag_q.pop_front();
        check(exp_tag, {out_data, overflow, underflow}, exp_v);
      end
    end
  end

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) break;
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eo, input logic eovf, input logic eunf,
                        input int min_lat);
    int lat;
    @(negedge clk);
    in_data_A = a;
    in_data_B = b;
    start     = 1'b1;
    sb_q.push_back({eo, eovf, eunf});
    tag_q.push_back(tag);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_done(tag, lat);
    check({tag, "_lat"}, (lat >= min_lat && lat <= 28), 1);
    check({tag, "_busy_in_done"}, busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold"}, {out_data, overflow, underflow}, {eo, eovf, eunf});
    check({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    int lat;
    int base;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, overflow, underflow, out_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("release_done", {done, overflow, underflow}, 0);

    run_op("equal",      32'h400D0000, 32'h400D0000, 32'h80000000, 1'b0, 1'b0, 4);
    run_op("norm_multi", 32'h40C68000, 32'h40CCE666, 32'hBE4CCCC0, 1'b0, 1'b0, 6);
    run_op("carry",      32'h40C68000, 32'hC0468000, 32'h4114E000, 1'b0, 1'b0, 4);
    run_op("eff_add",    32'h44090000, 32'hC0090000, 32'h44098900, 1'b0, 1'b0, 4);
    base = done_cnt;
    run_op("overflow",   32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0, 4);
    check("ovf_single_done", done_cnt - base, 1);
    run_op("underflow",  32'h00800001, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 4);
    run_op("two_m_one",  32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 4);
    run_op("zero_zero",  32'h00000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 4);
    run_op("zero_m_one", 32'h00000000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 4);

    // start held high across the whole operation with operands changing underneath
    @(negedge clk);
    in_data_A = 32'h40C68000;
    in_data_B = 32'h40CCE666;
    start     = 1'b1;
    sb_q.push_back({32'hBE4CCCC0, 1'b0, 1'b0});
    tag_q.push_back("held_start");
    base = done_cnt;
    @(posedge clk); #1;
    in_data_A = 32'h3F800000;
    in_data_B = 32'h12345678;
    wait_done("held_start", lat);
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("held_start_dones", done_cnt - base, 1);

    // reset in the middle of a long normalisation
    @(negedge clk);
    in_data_A = 32'h00800001;
    in_data_B = 32'h00800000;
    start     = 1'b1;
    sb_q.push_back({32'h00000000, 1'b0, 1'b1});
    tag_q.push_back("aborted");
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_norm_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", {busy, done, overflow, underflow, out_data}, 0);
    sb_q.delete();
    tag_q.delete();
    base = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt - base, 0);
    check("out_zero_after_abort", out_data, 0);

    run_op("after_reset", 32'h40C68000, 32'h40CCE666, 32'hBE4CCCC0, 1'b0, 1'b0, 6);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
